// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter: FSM states,
// port identifiers and default geometry of the instruction/data Memory.
package mem_arb_pkg;

    localparam int DEF_ADDR_W    = 13;
    localparam int DEF_DATA_W    = 18;
    localparam int DEF_MEM_DEPTH = 13;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a sole requester wins outright, a tie goes
// to the port that did not win last time. Purely combinational.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = (last_i == PORT_A) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port Memory between fetch port A (read-only) and
// load/store port B; one access in flight at a time, round-robin on ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_adrs,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_adrs,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              mem_re_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic              a_err_q, a_err_d, b_err_q, b_err_d;
    logic              re_en_q, re_en_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] adrs_q, adrs_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic [1:0]        pick;
    logic              win;
    logic [ADDR_W-1:0] sel_adrs;
    logic              sel_we;
    logic              sel_err;
    logic [DATA_W-1:0] resp_data;

    rr_arb2 u_rr_arb2 (
        .req_i  ({b_req, a_req}),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    assign win       = pick[PORT_B];
    assign sel_adrs  = win ? b_adrs : a_adrs;
    assign sel_we    = win & b_we;
    assign sel_err   = (sel_adrs >= ADDR_W'(MEM_DEPTH));
    assign resp_data = err_q ? '0 : mem_rdata;

    always_comb begin
        // NOTE: every _d gets a default here so no path leaves a latch behind.
        state_d    = state_q;
        last_d     = last_q;
        port_d     = port_q;
        we_d       = we_q;
        err_d      = err_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_err_d    = 1'b0;
        b_err_d    = 1'b0;
        re_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        adrs_d     = '0;
        wdata_d    = '0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d = ISSUE;
                    last_d  = win;
                    port_d  = win;
                    we_d    = sel_we;
                    err_d   = sel_err;
                    a_gnt_d = pick[PORT_A];
                    b_gnt_d = pick[PORT_B];
                    adrs_d  = sel_adrs;
                    wdata_d = sel_we ? b_wdata : '0;
                    re_en_d = ~sel_we & ~sel_err;
                    wr_en_d =  sel_we & ~sel_err;
                end
            end
            ISSUE: begin
                // In-range writes complete silently; everything else reports back.
                if (!we_q || err_q) begin
                    state_d    = RESP;
                    a_rvalid_d = (port_q == PORT_A);
                    b_rvalid_d = (port_q == PORT_B);
                    a_err_d    = (port_q == PORT_A) && err_q;
                    b_err_d    = (port_q == PORT_B) && err_q;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (port_q == PORT_B) b_rdata_d = resp_data;
                else                  a_rdata_d = resp_data;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: synchronous reset; sequential state is only ever assigned with <=.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= PORT_B;
            port_q     <= PORT_A;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
            re_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            adrs_q     <= '0;
            wdata_q    <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            port_q     <= port_d;
            we_q       <= we_d;
            err_q      <= err_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_err_q    <= a_err_d;
            b_err_q    <= b_err_d;
            re_en_q    <= re_en_d;
            wr_en_q    <= wr_en_d;
            adrs_q     <= adrs_d;
            wdata_q    <= wdata_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_err     = a_err_q;
    assign b_err     = b_err_q;
    assign mem_re_en = re_en_q;
    assign mem_wr_en = wr_en_q;
    assign mem_adrs  = adrs_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

    // Memory data only lands during RESP, so it is forwarded in that cycle
    // and captured into the hold register for the cycles that follow.
    assign a_rdata = a_rvalid_q ? resp_data : a_rdata_q;
    assign b_rdata = b_rvalid_q ? resp_data : b_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: memory stand-in, transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 13;
    localparam int DW    = 18;
    localparam int DEPTH = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_adrs = '0, b_adrs = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [DW-1:0] a_rdata, b_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_re_en, mem_wr_en, busy;
    logic [AW-1:0] mem_adrs;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_adrs(a_adrs), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_adrs(b_adrs), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_re_en(mem_re_en), .mem_wr_en(mem_wr_en), .mem_adrs(mem_adrs),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] img(input int i);
        if (i == 1)  return 18'b001000000000000011;
        if (i == 12) return 18'h3FFFF;
        return DW'(32'h10100 + i * 32'h123);
    endfunction

    // Synchronous-read memory image, reloaded on rst.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        logic [3:0] ix;
        ix = mem_adrs[3:0];
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= img(i);
            mem_rdata <= '0;
        end else begin
            if (mem_wr_en && mem_adrs < AW'(DEPTH)) mem[ix] <= mem_wdata;
            if (mem_re_en) mem_rdata <= (mem_adrs < AW'(DEPTH)) ? mem[ix] : '0;
        end
    end

    // Reference model: one pending access, described by the cycles at which
    // its grant and response appear, and the cycle the arbiter is free again.
    logic [DW-1:0] ref_mem [DEPTH];
    logic          model_on = 1'b0;
    logic          m_last = 1'b1;
    logic [DW-1:0] hold_a = '0, hold_b = '0;
    logic          p_v = 1'b0, p_port = 1'b0, p_we = 1'b0, p_err = 1'b0, p_resp = 1'b0;
    logic [AW-1:0] p_adrs = '0;
    logic [DW-1:0] p_wdata = '0, p_data = '0;
    int            p_g = 0, free_at = 0;

    always @(negedge clk) begin
        logic          g, r, win;
        logic [DW-1:0] ea, eb;
        logic [3:0]    ix;
        if (model_on) begin
            g = p_v && (cyc == p_g);
            r = p_v && p_resp && (cyc == p_g + 1);
            check("a_gnt",     32'(a_gnt),     32'(g && !p_port));
            check("b_gnt",     32'(b_gnt),     32'(g &&  p_port));
            check("mem_re_en", 32'(mem_re_en), 32'(g && !p_we && !p_err));
            check("mem_wr_en", 32'(mem_wr_en), 32'(g &&  p_we && !p_err));
            if (g) check("mem_adrs", 32'(mem_adrs), 32'(p_adrs));
            if (g && p_we && !p_err) check("mem_wdata", 32'(mem_wdata), 32'(p_wdata));
            check("a_rvalid", 32'(a_rvalid), 32'(r && !p_port));
            check("b_rvalid", 32'(b_rvalid), 32'(r &&  p_port));
            check("a_err",    32'(a_err),    32'(r && !p_port && p_err));
            check("b_err",    32'(b_err),    32'(r &&  p_port && p_err));
            check("busy",     32'(busy),     32'(p_v && cyc >= p_g && cyc < free_at));
            ea = (r && !p_port) ? p_data : hold_a;
            eb = (r &&  p_port) ? p_data : hold_b;
            check("a_rdata", 32'(a_rdata), 32'(ea));
            check("b_rdata", 32'(b_rdata), 32'(eb));
            hold_a = ea;
            hold_b = eb;
        end
        if (rst) begin
            model_on = 1'b1;
            m_last   = 1'b1;
            p_v      = 1'b0;
            free_at  = cyc + 1;
            hold_a   = '0;
            hold_b   = '0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = img(i);
        end else if (model_on && cyc >= free_at && (a_req || b_req)) begin
            win     = (a_req && b_req) ? ~m_last : b_req;
            m_last  = win;
            p_v     = 1'b1;
            p_port  = win;
            p_we    = win && b_we;
            p_adrs  = win ? b_adrs : a_adrs;
            p_wdata = b_wdata;
            p_err   = (p_adrs >= AW'(DEPTH));
            p_resp  = !p_we || p_err;
            p_g     = cyc + 1;
            free_at = p_resp ? cyc + 3 : cyc + 2;
            ix      = p_adrs[3:0];
            p_data  = p_err ? '0 : ref_mem[ix];
            if (p_we && !p_err) ref_mem[ix] = p_wdata;
        end
    end

    task automatic access(input logic port, input logic we, input logic [AW-1:0] adrs,
                          input logic [DW-1:0] wdata,
                          output logic rv, output logic [DW-1:0] rd, output logic er);
        int   n    = 0;
        logic seen = 1'b0;
        if (port) begin
            b_req = 1'b1; b_we = we; b_adrs = adrs; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_adrs = adrs;
        end
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = port ? b_gnt : a_gnt;
        end
        check("gnt_wait", 32'(seen), 32'd1);
        a_req = 1'b0;
        b_req = 1'b0;
        rv = 1'b0; rd = '0; er = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (port ? b_rvalid : a_rvalid) begin
                rv = 1'b1;
                rd = port ? b_rdata : a_rdata;
                er = port ? b_err : a_err;
            end
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic          rv, er;
        logic [DW-1:0] rd;
        logic          order[$];
        int            gc[$];
        int            n, low;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt",  32'({a_gnt, b_gnt, a_rvalid, b_rvalid}), 32'd0);

        // 1: A read of address 1, exact latency
        a_req = 1'b1; a_adrs = 13'd1;
        @(posedge clk); #1;
        check("t1_a_gnt", 32'(a_gnt), 32'd1);
        check("t1_re_en", 32'(mem_re_en), 32'd1);
        check("t1_adrs",  32'(mem_adrs), 32'd1);
        a_req = 1'b0;
        @(posedge clk); #1;
        check("t1_rvalid", 32'(a_rvalid), 32'd1);
        check("t1_rdata",  32'(a_rdata), 32'(18'b001000000000000011));
        check("t1_err",    32'(a_err), 32'd0);
        @(posedge clk); #1;

        // 2: B write then read back
        access(1'b1, 1'b1, 13'd5, 18'h2AAAA, rv, rd, er);
        check("t2_wr_no_rvalid", 32'(rv), 32'd0);
        access(1'b1, 1'b0, 13'd5, '0, rv, rd, er);
        check("t2_rd_rvalid", 32'(rv), 32'd1);
        check("t2_rd_data",   32'(rd), 32'h2AAAA);
        check("t2_rd_err",    32'(er), 32'd0);

        // 3: simultaneous held requests alternate, A first after reset
        pulse_rst();
        a_req = 1'b1; a_adrs = 13'd2;
        b_req = 1'b1; b_we = 1'b0; b_adrs = 13'd3;
        n = 0;
        while (order.size() < 4 && n < 40) begin
            @(posedge clk); #1;
            n++;
            check("t3_excl", 32'(mem_re_en && mem_wr_en), 32'd0);
            if (a_gnt) order.push_back(1'b0);
            if (b_gnt) order.push_back(1'b1);
        end
        a_req = 1'b0; b_req = 1'b0;
        check("t3_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < order.size()) check("t3_order", 32'(order[i]), 32'(i % 2));
        repeat (3) @(posedge clk);
        #1;

        // 4: out-of-range read and write on B
        access(1'b1, 1'b0, 13'd13, '0, rv, rd, er);
        check("t4_rd_rvalid", 32'(rv), 32'd1);
        check("t4_rd_data",   32'(rd), 32'd0);
        check("t4_rd_err",    32'(er), 32'd1);
        access(1'b1, 1'b1, 13'd8191, 18'h15555, rv, rd, er);
        check("t4_wr_rvalid", 32'(rv), 32'd1);
        check("t4_wr_err",    32'(er), 32'd1);
        for (int i = 0; i < DEPTH; i++) check("t4_mem_untouched", 32'(mem[i]), 32'(img(i)));

        // 5: reset during ISSUE aborts the A read
        a_req = 1'b1; a_adrs = 13'd3;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!a_gnt && n < 20);
        check("t5_gnt", 32'(a_gnt), 32'd1);
        a_req = 1'b0;
        pulse_rst();
        check("t5_ctl_zero", 32'({a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err,
                                  mem_re_en, mem_wr_en, busy}), 32'd0);
        check("t5_data_zero", 32'(mem_adrs) | 32'(mem_wdata) | 32'(a_rdata) | 32'(b_rdata), 32'd0);
        @(posedge clk); #1;
        check("t5_no_rvalid", 32'(a_rvalid), 32'd0);
        access(1'b0, 1'b0, 13'd12, '0, rv, rd, er);
        check("t5_rd12_rvalid", 32'(rv), 32'd1);
        check("t5_rd12_data",   32'(rd), 32'h3FFFF);

        // 6: back-to-back B reads
        b_req = 1'b1; b_we = 1'b0; b_adrs = 13'd4;
        n = 0; low = 0;
        while (gc.size() < 3 && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (b_gnt) gc.push_back(cyc);
            if (gc.size() == 1 && !busy) low++;
        end
        b_req = 1'b0;
        check("t6_count", 32'(gc.size()), 32'd3);
        if (gc.size() == 3) begin
            check("t6_gap1", 32'(gc[1] - gc[0]), 32'd3);
            check("t6_gap2", 32'(gc[2] - gc[1]), 32'd3);
        end
        check("t6_busy_low", 32'(low), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
